// File: rtl/downsample_avgpool_pkg.sv
// downsample_pkg: shared constants and the FSM state encoding for the 2x2
// average-pool downsampler.
//   state_e    : controller states IDLE/RUN/FLUSH/DONE
//   BASE_SIDE  : input side at size code 0 (side = BASE_SIDE << size)
//   MAX_SIZE   : largest size code; larger codes clamp to it
//   ADDR_W     : memory address width
//   READ_LAT   : input memory read latency in cycles
//   side_log2(): size code -> log2 of the input side
package downsample_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  localparam int         BASE_SIDE = 8;
  localparam int         BASE_LOG2 = $clog2(BASE_SIDE);
  localparam logic [2:0] MAX_SIZE  = 3'd4;
  localparam int         ADDR_W    = 14;
  localparam int         READ_LAT  = 1;
  // Drain after the last address: one cycle of read latency plus one for
  // the output register.
  localparam int         FLUSH_CYC = READ_LAT + 1;
  // Window row/column counters: up to 64 windows per side.
  localparam int         CNT_W     = 6;
  // Output pixel index: up to 64*64 windows.
  localparam int         IDX_W     = 2 * CNT_W;

  function automatic logic [2:0] side_log2(input logic [2:0] size);
    logic [2:0] s;
    s = (size > MAX_SIZE) ? MAX_SIZE : size;
    return s + 3'(BASE_LOG2);
  endfunction

endpackage

// File: rtl/downsample_avgpool_if.sv
// downsample_avgpool_if: start/done control plus input-memory read and
// output-memory write signals of the downsampler.
//   slave  : the downsampler side (drives done, addresses, write data/strobe)
//   master : controller + memory side (drives start, size, read data)
interface downsample_avgpool_if #(
  parameter int LENGTH = 16
) ();
  import downsample_pkg::*;

  logic              start;
  logic [2:0]        size_downsample;
  logic              done;
  logic [LENGTH-1:0] t_data_in;
  logic [ADDR_W-1:0] addr_input;
  logic [LENGTH-1:0] t_data_out;
  logic              en_write_out;
  logic [ADDR_W-1:0] addr_output;

  modport slave (
    input  start, size_downsample, t_data_in,
    output done, addr_input, t_data_out, en_write_out, addr_output
  );

  modport master (
    output start, size_downsample, t_data_in,
    input  done, addr_input, t_data_out, en_write_out, addr_output
  );

endinterface

// File: rtl/downsample_addr_gen.sv
// downsample_addr_gen: walks the 2x2 windows of a W x W map in row-major
// window order, four reads per window, and registers the read address.
//   load_i    : start a pass (latches size_i)
//   size_i    : size code, 0..7 (5..7 clamp to 4)
//   addr_o    : registered input read address (0 when inactive)
//   last_o    : addr_o currently holds the final read of the pass
//   tag_*_o   : valid/k/window index of the read whose data arrives now
module downsample_addr_gen
  import downsample_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic [2:0]        size_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic              last_o,
  output logic              tag_vld_o,
  output logic [1:0]        tag_k_o,
  output logic [IDX_W-1:0]  tag_idx_o
);

  localparam logic [CNT_W:0] ONE = 1;

  logic              active_q, active_d;
  logic [1:0]        k_q, k_d;
  logic [CNT_W-1:0]  c_q, c_d, r_q, r_d;
  logic [2:0]        lw_q, lw_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              tag_vld_q;
  logic [1:0]        tag_k_q;
  logic [IDX_W-1:0]  tag_idx_q;

  logic [CNT_W:0]    half, half_m1;
  logic              wrap_k, wrap_c, wrap_r;
  logic [IDX_W-1:0]  idx;

  // Row of the element is 2r+k[1], column 2c+k[0]; W is a power of two so
  // the row term is a shift by log2(W).
  function automatic logic [ADDR_W-1:0] elem_addr(
    input logic [CNT_W-1:0] r, input logic [CNT_W-1:0] c,
    input logic [1:0] k, input logic [2:0] lw);
    logic [ADDR_W-1:0] row, col;
    row = {{(ADDR_W-CNT_W-1){1'b0}}, r, k[1]};
    col = {{(ADDR_W-CNT_W-1){1'b0}}, c, k[0]};
    return (row << lw) | col;
  endfunction

  assign half    = ONE << (lw_q - 3'd1);
  assign half_m1 = half - ONE;
  assign wrap_k  = (k_q == 2'd3);
  assign wrap_c  = (c_q == half_m1[CNT_W-1:0]);
  assign wrap_r  = (r_q == half_m1[CNT_W-1:0]);
  assign last_o  = active_q & wrap_k & wrap_c & wrap_r;
  assign idx     = ({{(IDX_W-CNT_W){1'b0}}, r_q} << (lw_q - 3'd1))
                 | {{(IDX_W-CNT_W){1'b0}}, c_q};

  always_comb begin
    active_d = active_q;
    k_d      = k_q;
    c_d      = c_q;
    r_d      = r_q;
    lw_d     = lw_q;
    if (load_i) begin
      active_d = 1'b1;
      k_d      = '0;
      c_d      = '0;
      r_d      = '0;
      lw_d     = side_log2(size_i);
    end else if (active_q) begin
      if (last_o) begin
        active_d = 1'b0;
        k_d      = '0;
        c_d      = '0;
        r_d      = '0;
      end else begin
        k_d = k_q + 2'd1;
        if (wrap_k) begin
          c_d = wrap_c ? '0 : c_q + 1'b1;
          if (wrap_c) r_d = r_q + 1'b1;
        end
      end
    end
    // Address is registered from the next counter values so addr_o and the
    // counters always describe the same element.
    addr_d = active_d ? elem_addr(r_d, c_d, k_d, lw_d) : '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      active_q  <= 1'b0;
      k_q       <= '0;
      c_q       <= '0;
      r_q       <= '0;
      lw_q      <= 3'(BASE_LOG2);
      addr_q    <= '0;
      tag_vld_q <= 1'b0;
      tag_k_q   <= '0;
      tag_idx_q <= '0;
    end else begin
      active_q  <= active_d;
      k_q       <= k_d;
      c_q       <= c_d;
      r_q       <= r_d;
      lw_q      <= lw_d;
      addr_q    <= addr_d;
      // Data for addr_q returns one cycle later; delay its tag to match.
      tag_vld_q <= active_q;
      tag_k_q   <= k_q;
      tag_idx_q <= idx;
    end
  end

  assign addr_o    = addr_q;
  assign tag_vld_o = tag_vld_q;
  assign tag_k_o   = tag_k_q;
  assign tag_idx_o = tag_idx_q;

endmodule

// File: rtl/downsample_avgpool.sv
// downsample_avgpool: reduces a W x W signed feature map to (W/2) x (W/2)
// by averaging each non-overlapping 2x2 window (floor toward -inf).
//   clk, rst : clock, asynchronous active-low reset
//   bus      : start/size/done control, input read port (addr_input,
//              t_data_in, 1-cycle latency), output write port
//              (addr_output, t_data_out, en_write_out)
module downsample_avgpool
  import downsample_pkg::*;
#(
  parameter int length = 16
) (
  input logic                  clk,
  input logic                  rst,
  downsample_avgpool_if.slave  bus
);

  state_e state_q, state_d;
  logic [1:0] fcnt_q, fcnt_d;
  logic       load;
  logic       done_q, done_d;

  logic              ag_last, tag_vld;
  logic [1:0]        tag_k;
  logic [IDX_W-1:0]  tag_idx;
  logic [ADDR_W-1:0] addr_in;

  logic signed [length+1:0] acc_q, acc_d, din, sum, avg;
  logic [length-1:0]        dout_q, dout_d;
  logic [ADDR_W-1:0]        aout_q, aout_d;
  logic                     en_q, en_d;

  downsample_addr_gen u_addr_gen (
    .clk       (clk),
    .rst       (rst),
    .load_i    (load),
    .size_i    (bus.size_downsample),
    .addr_o    (addr_in),
    .last_o    (ag_last),
    .tag_vld_o (tag_vld),
    .tag_k_o   (tag_k),
    .tag_idx_o (tag_idx)
  );

  always_comb begin
    state_d = state_q;
    fcnt_d  = '0;
    load    = 1'b0;
    case (state_q)
      S_IDLE: if (bus.start) begin
        load    = 1'b1;
        state_d = S_RUN;
      end
      S_RUN:  if (ag_last) state_d = S_FLUSH;
      S_FLUSH: begin
        fcnt_d = fcnt_q + 2'd1;
        if (fcnt_q == 2'(FLUSH_CYC - 1)) state_d = S_DONE;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    done_d = (state_d == S_DONE);
  end

  // Four signed samples need two guard bits; the shifted mean always fits
  // back into length bits.
  assign din = {{2{bus.t_data_in[length-1]}}, bus.t_data_in};
  assign sum = acc_q + din;
  assign avg = sum >>> 2;

  always_comb begin
    acc_d  = acc_q;
    en_d   = 1'b0;
    dout_d = '0;
    aout_d = '0;
    if (tag_vld) begin
      case (tag_k)
        2'd0:    acc_d = din;
        2'd3: begin
          en_d   = 1'b1;
          dout_d = avg[length-1:0];
          aout_d = {{(ADDR_W-IDX_W){1'b0}}, tag_idx};
        end
        default: acc_d = sum;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      fcnt_q  <= '0;
      done_q  <= 1'b0;
      acc_q   <= '0;
      en_q    <= 1'b0;
      dout_q  <= '0;
      aout_q  <= '0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
      done_q  <= done_d;
      acc_q   <= acc_d;
      en_q    <= en_d;
      dout_q  <= dout_d;
      aout_q  <= aout_d;
    end
  end

  assign bus.done         = done_q;
  assign bus.addr_input   = addr_in;
  assign bus.t_data_out   = dout_q;
  assign bus.en_write_out = en_q;
  assign bus.addr_output  = aout_q;

endmodule

// File: doc/downsample_avgpool.md
# downsample_avgpool

Feature-map 2x downsampler: the reverse direction of the upsampling path. It reads a square W x W map from input memory via `addr_input`, reduces every non-overlapping 2x2 window to its arithmetic mean, and writes the (W/2) x (W/2) result via `addr_output`/`en_write_out`. It sits between generator feature-map buffers, with the same start/done, addressing and memory conventions as the upsampling unit.

## Interface
- `length`, default 16: data width, signed two's-complement fixed point.
- `clk  in  1`: single clock, rising edge.
- `rst  in  1`: asynchronous, active-low reset.
- `start  in  1`: begin a pass; sampled only in IDLE.
- `size_downsample  in  3`: input side W = 8 << size_downsample. 0..4 gives 8..128; values 5..7 are treated as 4.
- `done  out  1`: one-cycle pulse when the pass is complete.
- `t_data_in  in  length`: input memory read data, valid one cycle after `addr_input`.
- `addr_input  out  14`: input memory read address, row-major, `row*W + col`.
- `t_data_out  out  length`: averaged pixel.
- `en_write_out  out  1`: output memory write strobe, one cycle per output pixel.
- `addr_output  out  14`: output memory write address, row-major, `r*(W/2) + c`.

## Operation
- States:
  - IDLE: `start`=1 latches the size and moves to RUN.
  - RUN: issues one read address per cycle; after the last read of the last window, moves to FLUSH.
  - FLUSH: waits 2 cycles to drain the pipeline, then moves to DONE.
  - DONE: `done`=1 for one cycle, then IDLE.
- Counters:
  - r, c: 0..W/2-1. c is inner; it wraps to 0 and increments r.
  - k: 0..3, window element.
  - Element order: k0=(2r,2c), k1=(2r,2c+1), k2=(2r+1,2c), k3=(2r+1,2c+1).
  - `addr_input` = (2r + k[1])*W + 2c + k[0].
- Datapath:
  - A one-cycle-delayed valid/k/index tag accompanies each read.
  - The accumulator is length+2 bits, sign-extended.
  - Tag k0 loads the accumulator with `t_data_in`.
  - Tags k1 and k2 add `t_data_in` to it.
  - Tag k3 computes (acc + `t_data_in`) >>> 2 (arithmetic shift, floor toward -inf) and registers the low `length` bits into `t_data_out`, the window index into `addr_output`, and 1 into `en_write_out`.
- No saturation is needed: the mean of in-range values is always in range.
- `start` outside IDLE is ignored. `size_downsample` is sampled only on accepted start; later changes do not affect the running pass.
- Reset (at any time, including mid-pass): all state and outputs clear immediately; FSM returns to IDLE. No partial write is emitted after reset release.

## Timing
- Reset and idle values: `done`=0, `en_write_out`=0, `t_data_out`=0, `addr_input`=0, `addr_output`=0.
- `t_data_out` and `addr_output` return to 0 in every cycle where `en_write_out`=0.
- Cycle 0: `start` sampled high.
- Cycle 1: first `addr_input` (window 0, k0).
- Addresses are back-to-back, 4 cycles per window, no bubbles.
- Read latency is fixed at 1 cycle.
- Window i: `en_write_out` high in cycle 4i+6.
- With N = (W/2)^2:
  - last write occurs in cycle 4N+2;
  - `done` is high in cycle 4N+3;
  - IDLE from cycle 4N+4, and a new `start` is accepted in that cycle.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Structure
- `downsample_pkg` holds:
  - the state encoding (IDLE/RUN/FLUSH/DONE);
  - the size decode constant (base side 8, max size code 4);
  - the address width 14;
  - the read latency 1.
- One sub-module, `downsample_addr_gen`: r/c/k counters, `addr_input` generation, last-read flag, and the delayed tag.
- The top level holds the FSM, accumulator and output registers.

## Test plan
- **8x8 ramp**: memory[a]=a, size 0.
  - Window (0,0): 0,1,8,9 → 4 at `addr_output` 0.
  - Window (3,3): 54,55,62,63 → 58 at `addr_output` 15.
  - 16 writes total; `done` in cycle 67.
- **Rounding**:
  - Window of -1,-2,-3,-4 → 0xFFFD (-3).
  - Window of 1,1,1,2 → 1.
- **Extremes**:
  - All 0x7FFF → 0x7FFF.
  - All 0x8000 → 0x8000.
  - Mixed 0x7FFF,0x7FFF,0x8000,0x8000 → 0xFFFF.
- **128x128, size 4**:
  - Last `addr_input` 16383; 4096 writes; last `addr_output` 4095; `done` in cycle 16387.
  - size 6 behaves identically.
- **Start while busy**: pulse `start` in cycle 20 of an 8x8 pass.
  - Ignored: write count, addresses and `done` cycle are unchanged.
  - A `start` in the first IDLE cycle after `done` launches a correct second pass.
- **Reset mid-pass**: assert `rst` in cycle 30 of an 8x8 pass.
  - All outputs go to 0 immediately.
  - After release: no `en_write_out`, no `done` until a new `start`; that pass then completes with correct results.
